// File: rtl/alu_sequencer.sv
// alu_sequencer: push-button operand/opcode loader for a combinational ALU.
// The raw button is synchronized and debounced. Each debounced press steps
// a small FSM: load A, then B, then the opcode. It then spends one cycle
// latching the ALU result, and shows it until the next press.
module alu_sequencer #(
  parameter int NB_DATA     = 4,
  parameter int NB_OP       = 6,
  parameter int DBNC_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_btn,
  input  logic               i_clear,
  input  logic [NB_OP-1:0]   i_dato,
  input  logic [NB_DATA-1:0] i_result,
  output logic [NB_DATA-1:0] o_datoA,
  output logic [NB_DATA-1:0] o_datoB,
  output logic [NB_OP-1:0]   o_op,
  output logic [NB_DATA-1:0] o_leds,
  output logic [2:0]         o_state,
  output logic               o_done
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  // The last count value before the debounced level is allowed to follow.
  localparam logic [23:0] CNT_LAST = 24'(DBNC_CYCLES - 1);

  logic        sync1_q, sync2_q;
  logic        dbnc_q, dbnc_d;
  logic [23:0] cnt_q, cnt_d;
  logic        pulse_q, pulse_d;

  state_t               state_q;
  logic [NB_DATA-1:0]   datoa_q, datob_q, leds_q;
  logic [NB_OP-1:0]     op_q;
  logic                 done_q;

  // Debounce: count the cycles the synchronized level disagrees with the
  // accepted level, and accept it once the disagreement has lasted long
  // enough. The pulse is taken from the next level (dbnc_d), not from
  // dbnc_q. This puts it in the same cycle the level flips, which keeps the
  // press-to-capture latency at one clock past the debounce window.
  always_comb begin
    dbnc_d = dbnc_q;
    cnt_d  = '0;
    if (sync2_q != dbnc_q) begin
      if (cnt_q == CNT_LAST) dbnc_d = sync2_q;
      else                   cnt_d  = cnt_q + 24'd1;
    end
    pulse_d = dbnc_d & ~dbnc_q;
  end

  // Synchronizer and debouncer state. The abort input does not touch these.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dbnc_q  <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
      dbnc_q  <= dbnc_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  // Sequencer FSM with registered outputs. Abort beats a press. A press
  // that arrives during the one-cycle execute state is dropped.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_A;
      datoa_q <= '0;
      datob_q <= '0;
      op_q    <= '0;
      leds_q  <= '0;
      done_q  <= 1'b0;
    end else if (i_clear) begin
      state_q <= S_A;
      datoa_q <= '0;
      datob_q <= '0;
      op_q    <= '0;
      leds_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_A: if (pulse_q) begin
          datoa_q <= i_dato[NB_DATA-1:0];
          state_q <= S_B;
        end
        S_B: if (pulse_q) begin
          datob_q <= i_dato[NB_DATA-1:0];
          state_q <= S_OP;
        end
        S_OP: if (pulse_q) begin
          op_q    <= i_dato;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          leds_q  <= i_result;
          done_q  <= 1'b1;
          state_q <= S_SHOW;
        end
        S_SHOW: if (pulse_q) begin
          done_q  <= 1'b0;
          state_q <= S_A;
        end
        default: state_q <= S_A;
      endcase
    end
  end

  assign o_datoA = datoa_q;
  assign o_datoB = datob_q;
  assign o_op    = op_q;
  assign o_leds  = leds_q;
  assign o_state = state_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a short debounce window (4 cycles).
module tb_alu_sequencer;

  localparam int NB_DATA = 4;
  localparam int NB_OP   = 6;
  localparam int DBNC    = 4;

  logic               clk = 1'b0;
  logic               i_rst_n;
  logic               i_btn;
  logic               i_clear;
  logic [NB_OP-1:0]   i_dato;
  logic [NB_DATA-1:0] i_result;
  logic [NB_DATA-1:0] o_datoA, o_datoB, o_leds;
  logic [NB_OP-1:0]   o_op;
  logic [2:0]         o_state;
  logic               o_done;

  int checks = 0;
  int errors = 0;

  alu_sequencer #(.NB_DATA(NB_DATA), .NB_OP(NB_OP), .DBNC_CYCLES(DBNC)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_btn(i_btn), .i_clear(i_clear),
    .i_dato(i_dato), .i_result(i_result),
    .o_datoA(o_datoA), .o_datoB(o_datoB), .o_op(o_op), .o_leds(o_leds),
    .o_state(o_state), .o_done(o_done)
  );

  always #5 clk = ~clk;

  // One clean press: hold high long enough to debounce, then release.
  task automatic press(input logic [NB_OP-1:0] d);
    @(negedge clk);
    i_dato = d;
    i_btn  = 1'b1;
    repeat (12) @(negedge clk);
    i_btn = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk);
    i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_btn = 1'b0; i_clear = 1'b0; i_dato = '0; i_result = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_datoA, o_datoB, o_op, o_leds, o_state, o_done} !== '0) begin
      errors++;
      $display("FAIL reset_state got A=%h B=%h op=%h leds=%h st=%0d done=%b exp all 0",
               o_datoA, o_datoB, o_op, o_leds, o_state, o_done);
    end
    i_rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // The capture lands on the 7th rising edge after the button rises.
  task automatic test_latency();
    @(negedge clk);
    i_dato = 6'h0A;
    i_btn  = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (o_state !== 3'd0) begin
      errors++;
      $display("FAIL latency_early got st=%0d exp 0", o_state);
    end
    @(negedge clk);
    checks++;
    if (o_state !== 3'd1 || o_datoA !== 4'hA) begin
      errors++;
      $display("FAIL latency_capture got st=%0d A=%h exp st=1 A=a", o_state, o_datoA);
    end
    i_btn = 1'b0;
    repeat (12) @(negedge clk);
    do_clear();
  endtask

  task automatic test_full_sequence();
    i_result = 4'h8;
    press(6'h03);
    press(6'h05);
    press(6'h20);
    checks++;
    if (o_datoA !== 4'h3 || o_datoB !== 4'h5 || o_op !== 6'h20 || o_leds !== 4'h8 ||
        o_done !== 1'b1 || o_state !== 3'd4) begin
      errors++;
      $display("FAIL full_seq got A=%h B=%h op=%h leds=%h done=%b st=%0d exp 3 5 20 8 1 4",
               o_datoA, o_datoB, o_op, o_leds, o_done, o_state);
    end
  endtask

  task automatic test_return();
    i_result = 4'hF;
    press(6'h00);
    checks++;
    if (o_state !== 3'd0 || o_done !== 1'b0 || o_leds !== 4'h8) begin
      errors++;
      $display("FAIL return got st=%0d done=%b leds=%h exp 0 0 8", o_state, o_done, o_leds);
    end
    checks++;
    if (o_datoA !== 4'h3 || o_datoB !== 4'h5 || o_op !== 6'h20) begin
      errors++;
      $display("FAIL return_hold got A=%h B=%h op=%h exp 3 5 20", o_datoA, o_datoB, o_op);
    end
  endtask

  task automatic test_abort();
    press(6'h03);
    press(6'h05);
    checks++;
    if (o_state !== 3'd2) begin
      errors++;
      $display("FAIL abort_setup got st=%0d exp 2", o_state);
    end
    do_clear();
    checks++;
    if ({o_datoA, o_datoB, o_op, o_leds, o_state, o_done} !== '0) begin
      errors++;
      $display("FAIL abort got A=%h B=%h op=%h leds=%h st=%0d done=%b exp all 0",
               o_datoA, o_datoB, o_op, o_leds, o_state, o_done);
    end
  endtask

  task automatic test_bounce();
    int changes = 0;
    logic [2:0] prev;
    prev = o_state;
    i_dato = 6'h07;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      i_btn = ((i / 2) % 2 == 0);
      if (o_state !== prev) changes++;
      prev = o_state;
    end
    i_btn = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 15) i_btn = 1'b0;
      if (o_state !== prev) changes++;
      prev = o_state;
    end
    checks++;
    if (changes != 1 || o_state !== 3'd1 || o_datoA !== 4'h7) begin
      errors++;
      $display("FAIL bounce got changes=%0d st=%0d A=%h exp 1 1 7", changes, o_state, o_datoA);
    end
    do_clear();
  endtask

  // The abort is raised so that it coincides with the edge that would capture.
  task automatic test_collision();
    @(negedge clk);
    i_dato = 6'h09;
    i_btn  = 1'b1;
    repeat (6) @(negedge clk);
    i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;
    checks++;
    if (o_datoA !== 4'h0 || o_state !== 3'd0) begin
      errors++;
      $display("FAIL collision got A=%h st=%0d exp 0 0", o_datoA, o_state);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (o_state !== 3'd0) begin
      errors++;
      $display("FAIL collision_no_late got st=%0d exp 0", o_state);
    end
    i_btn = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_mid_reset();
    i_result = 4'h6;
    press(6'h03);
    checks++;
    if (o_state !== 3'd1 || o_datoA !== 4'h3) begin
      errors++;
      $display("FAIL midrst_setup got st=%0d A=%h exp 1 3", o_state, o_datoA);
    end
    @(negedge clk);
    i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_datoA, o_datoB, o_op, o_leds, o_state, o_done} !== '0) begin
      errors++;
      $display("FAIL midrst_async got A=%h B=%h op=%h leds=%h st=%0d done=%b exp all 0",
               o_datoA, o_datoB, o_op, o_leds, o_state, o_done);
    end
    i_btn = 1'b1;
    i_dato = 6'h0C;
    repeat (3) @(negedge clk);
    i_rst_n = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (o_state !== 3'd1 || o_datoA !== 4'hC) begin
      errors++;
      $display("FAIL held_btn got st=%0d A=%h exp 1 c", o_state, o_datoA);
    end
    i_btn = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (o_state !== 3'd1) begin
      errors++;
      $display("FAIL release_no_pulse got st=%0d exp 1", o_state);
    end
    do_clear();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_full_sequence();
    test_return();
    test_abort();
    test_bounce();
    test_collision();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 4, the operand width.
REQ-002 The block SHALL have parameter NB_OP, default 6, the opcode width.
REQ-003 The block SHALL have parameter DBNC_CYCLES, default 1000000, the stable-level cycles needed to accept a button change; legal range 2 to 2^24.
REQ-004 Ports SHALL be, in order:
- clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_btn  in  1  raw load push-button, asynchronous, active-high
- i_clear  in  1  synchronous abort, active-high
- i_dato  in  NB_OP  switch data
- i_result  in  NB_DATA  combinational ALU result
- o_datoA  out  NB_DATA  operand A to ALU
- o_datoB  out  NB_DATA  operand B to ALU
- o_op  out  NB_OP  opcode to ALU
- o_leds  out  NB_DATA  latched result
- o_state  out  3  FSM state code
- o_done  out  1  result-valid flag

Function
REQ-005 i_btn SHALL pass through a two-flop synchronizer before any other use.
REQ-006 Debounce: a 24-bit counter SHALL increment each cycle the synchronized level differs from the debounced level; it SHALL clear when they match.
REQ-007 The debounced level SHALL take the synchronized value, and the counter SHALL clear, on the cycle the counter reaches DBNC_CYCLES-1 while the levels still differ.
REQ-008 A one-cycle load pulse SHALL be registered on each 0->1 transition of the debounced level; 1->0 transitions SHALL generate no pulse.
REQ-009 FSM states and o_state codes SHALL be S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_SHOW=4.
REQ-010 S_A on load pulse: capture i_dato[NB_DATA-1:0] into o_datoA, go to S_B.
REQ-011 S_B on load pulse: capture i_dato[NB_DATA-1:0] into o_datoB, go to S_OP.
REQ-012 S_OP on load pulse: capture the full i_dato into o_op, go to S_EXEC.
REQ-013 S_EXEC SHALL last exactly one cycle with no pulse needed: register i_result into o_leds, set o_done, go to S_SHOW.
REQ-014 S_SHOW on load pulse: clear o_done, go to S_A; o_datoA, o_datoB, o_op and o_leds hold.
REQ-015 Without a load pulse, every state except S_EXEC SHALL hold, and all outputs SHALL hold.
REQ-016 i_clear SHALL take priority over a load pulse in the same cycle: go to S_A, zero o_datoA, o_datoB, o_op and o_leds, and clear o_done.
REQ-017 i_clear SHALL NOT reset the synchronizer or the debouncer.
REQ-018 A load pulse arriving during S_EXEC SHALL be discarded.
REQ-019 Undefined state codes 5-7 SHALL recover to S_A on the next clock.
REQ-020 All outputs SHALL be driven directly from registers.
REQ-021 Latency from an i_btn rise, stable throughout, to the capture edge SHALL be 2 + DBNC_CYCLES + 1 clocks, constant.

Reset
REQ-022 While i_rst_n is low, all registers SHALL be cleared asynchronously: state S_A, o_datoA=0, o_datoB=0, o_op=0, o_leds=0, o_done=0, o_state=0, synchronizer=0, debounced level=0, counter=0, pulse=0.
REQ-023 After i_rst_n is released, the first active clock edge SHALL operate normally; a reset mid-sequence SHALL discard any partial capture.
REQ-024 If i_btn is held high through reset release, it SHALL produce exactly one load pulse once it has been stable for DBNC_CYCLES cycles.

Verification (DBNC_CYCLES=4)
REQ-025 Full sequence: i_dato=0x03, press; i_dato=0x05, press; i_dato=0x20, press; i_result=0x8 -> o_datoA=3, o_datoB=5, o_op=0x20, o_leds=8, o_done=1, o_state=4.
REQ-026 Bounce: i_btn toggles every 2 cycles for 20 cycles, then stays high -> exactly one load pulse and one state advance.
REQ-027 Abort: i_clear in S_OP with o_datoA=3 and o_datoB=5 -> o_state=0, all data outputs 0, o_done=0 on the next cycle.
REQ-028 Collision: i_clear and a load pulse in the same cycle in S_A -> o_datoA=0, o_state=0.
REQ-029 Mid-sequence reset: i_rst_n low in S_B -> all outputs 0 immediately, without a clock.
REQ-030 Return: press in S_SHOW -> o_state=0 and o_done=0, with o_leds unchanged.
